// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button input conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int SYNC_STAGES         = 2;
  localparam int CLK_HZ              = 100_000_000;
  localparam int DEF_NUM_BTN         = 4;
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
  localparam int DEF_HOLD_CYCLES     = CLK_HZ;        // 1 s
  localparam bit DEF_ACTIVE_LOW      = 1'b1;

endpackage

// File: rtl/btn_debounce_channel.sv
// One button channel: synchronizer, debounce FSM with stability counter,
// registered press/release pulses and a once-per-press long-hold pulse.
module btn_debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold
);

  localparam int STAB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(HOLD_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  btn_state_t             r_state;
  btn_state_t             w_state_nxt;
  logic [STAB_W-1:0]      r_stab;
  logic [STAB_W-1:0]      w_stab_nxt;
  logic [HCNT_W-1:0]      r_hcnt;
  logic                   r_press;
  logic                   r_release;
  logic                   r_hold;
  logic                   w_s;
  logic                   w_level;
  logic                   w_press_nxt;
  logic                   w_release_nxt;

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_level = (r_state == PRESSED) || (r_state == RELEASE_WAIT);

  // Normalised to 1 = pressed before entering the synchronizer, so reset loads "not pressed".
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw ^ ACTIVE_LOW};
    end
  end

  // The counter only runs while s disagrees with the accepted level; any agreement clears it.
  always_comb begin
    w_state_nxt   = r_state;
    w_stab_nxt    = '0;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      RELEASED, PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = RELEASED;
        end else if (r_stab == STAB_LAST) begin
          w_state_nxt = PRESSED;
          w_press_nxt = 1'b1;
        end else begin
          w_state_nxt = PRESS_WAIT;
          w_stab_nxt  = r_stab + 1'b1;
        end
      end
      PRESSED, RELEASE_WAIT: begin
        if (w_s) begin
          w_state_nxt = PRESSED;
        end else if (r_stab == STAB_LAST) begin
          w_state_nxt   = RELEASED;
          w_release_nxt = 1'b1;
        end else begin
          w_state_nxt = RELEASE_WAIT;
          w_stab_nxt  = r_stab + 1'b1;
        end
      end
      default: w_state_nxt = RELEASED;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= RELEASED;
      r_stab    <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_stab    <= w_stab_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Hold counter starts from the press edge and saturates, so the pulse fires once per press.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hcnt <= '0;
      r_hold <= 1'b0;
    end else begin
      r_hold <= w_level && (r_hcnt == HCNT_LAST);
      if (!w_level) begin
        r_hcnt <= '0;
      end else if (r_hcnt != HCNT_MAX) begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end
  end

  assign o_level   = w_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_hold    = r_hold;

endmodule

// File: rtl/button_input_conditioner.sv
// Conditions NUM_BTN raw push-button pins into debounced levels and event pulses.
module button_input_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_BTN-1:0] BTN_RAW,
  output logic [NUM_BTN-1:0] BTN_LEVEL,
  output logic [NUM_BTN-1:0] BTN_PRESS,
  output logic [NUM_BTN-1:0] BTN_RELEASE,
  output logic [NUM_BTN-1:0] BTN_HOLD
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .i_clk    (CLK),
      .i_rst    (RST),
      .i_raw    (BTN_RAW[i]),
      .o_level  (BTN_LEVEL[i]),
      .o_press  (BTN_PRESS[i]),
      .o_release(BTN_RELEASE[i]),
      .o_hold   (BTN_HOLD[i])
    );
  end

endmodule
